// File: rtl/seq_divider.sv
// Sequential signed divider: restoring algorithm, one quotient bit per clock.
// Quotient rounds toward zero, remainder takes the sign of the dividend.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; results from the last operation held
// S_CALC | WIDTH restoring iterations on the operand magnitudes
// S_FIX  | apply signs / special cases, register results, pulse done
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;      // original dividend, returned as remainder on divide by zero
   logic [WIDTH-1:0] r_dvs;      // |divisor|; |MIN_NEG| fits as an unsigned WIDTH-bit value
   logic [WIDTH-1:0] r_quo;      // dividend magnitude shifts out MSB-first, quotient bits shift in
   logic [WIDTH-1:0] r_rem;      // partial remainder, always below r_dvs after an iteration
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_dz;
   logic             r_ov;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;
   logic             r_overflow;

   logic             w_accept;
   logic [WIDTH-1:0] w_abs_dvd;
   logic [WIDTH-1:0] w_abs_dvs;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_neg_quo;
   logic [WIDTH-1:0] w_neg_rem;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_abs_dvd = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
   assign w_abs_dvs = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_dvs});
   // when w_ge holds the true difference is below r_dvs, so the low bits are exact
   assign w_diff    = w_shift[WIDTH-1:0] - r_dvs;
   assign w_neg_quo = ~r_quo + WIDTH'(1);
   assign w_neg_rem = ~r_rem + WIDTH'(1);

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;
   assign overflow    = r_overflow;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (r_cnt == LAST_CNT) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, restoring iterations and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_dvd         <= '0;
         r_dvs         <= '0;
         r_quo         <= '0;
         r_rem         <= '0;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_dz          <= 1'b0;
         r_ov          <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dvd    <= dividend;
                  r_dvs    <= w_abs_dvs;
                  r_quo    <= w_abs_dvd;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_sign_r <= dividend[WIDTH-1];
                  r_dz     <= (divisor == '0);
                  r_ov     <= (dividend == MIN_NEG) && (divisor == ALL_ONES);
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_div_by_zero <= r_dz;
               r_overflow    <= r_ov;
               if (r_dz) begin
                  // saturate toward the dividend's sign, remainder is the dividend itself
                  r_quotient  <= r_sign_r ? MIN_NEG : MAX_POS;
                  r_remainder <= r_dvd;
               end else if (r_ov) begin
                  r_quotient  <= MIN_NEG;
                  r_remainder <= '0;
               end else begin
                  r_quotient  <= r_sign_q ? w_neg_quo : r_quo;
                  r_remainder <= r_sign_r ? w_neg_rem : r_rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: table of signed operand cases with hand-derived
// results fed through a scoreboard queue, plus handshake and reset sequences.
module tb_seq_divider;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
   } vec_t;

   localparam int NV = 13;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
   logic       overflow;

   int   n_tests;
   int   n_fail;
   vec_t sb[$];
   vec_t tv[NV];

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one request while idle; returns #1 after the accepting edge.
   task automatic start_op(input vec_t v);
      @(negedge clk);
      dividend = v.a;
      divisor  = v.b;
      start    = 1'b1;
      sb.push_back(v);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
   endtask

   // Wait for done (bounded), pop the scoreboard and compare.
   task automatic wait_done(input string nm, input int exp_lat, input int exp_busy);
      int   lat;
      int   nbusy;
      vec_t e;
      lat   = 0;
      nbusy = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) nbusy++;
      end
      if (lat == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no done, expected done within 30 edges", nm);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_sb: got done, expected no pending result", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_latency"},   lat,         exp_lat);
         chk({nm, "_busy_cyc"},  nbusy,       exp_busy);
         chk({nm, "_busy_done"}, busy,        1'b0);
         chk({nm, "_q"},         quotient,    e.q);
         chk({nm, "_r"},         remainder,   e.r);
         chk({nm, "_dz"},        div_by_zero, e.dz);
         chk({nm, "_ov"},        overflow,    e.ov);
         @(posedge clk);
         #1;
         chk({nm, "_done_pulse"}, done, 1'b0);
      end
   endtask

   task automatic expect_quiet(input string nm, input int n);
      int cnt;
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
      chk({nm, "_no_done"}, cnt, 0);
   endtask

   initial begin
      vec_t a;
      vec_t b;
      n_tests  = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      //          a      b      q      r     dz    ov
      tv[0]  = '{8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0}; // 100/7
      tv[1]  = '{8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0}; // -100/7
      tv[2]  = '{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0}; // 100/-7
      tv[3]  = '{8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0}; // -100/-7
      tv[4]  = '{8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1}; // -128/-1
      tv[5]  = '{8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0}; // -128/1
      tv[6]  = '{8'h7F,  8'h80, 8'h00, 8'h7F, 1'b0, 1'b0}; // 127/-128
      tv[7]  = '{8'h80,  8'h80, 8'h01, 8'h00, 1'b0, 1'b0}; // -128/-128
      tv[8]  = '{8'd5,   8'd0,  8'h7F, 8'h05, 1'b1, 1'b0}; // 5/0
      tv[9]  = '{8'hFD,  8'd0,  8'h80, 8'hFD, 1'b1, 1'b0}; // -3/0
      tv[10] = '{8'd50,  8'd5,  8'h0A, 8'h00, 1'b0, 1'b0}; // 50/5
      tv[11] = '{8'hF9,  8'd2,  8'hFD, 8'hFF, 1'b0, 1'b0}; // -7/2
      tv[12] = '{8'd0,   8'd5,  8'h00, 8'h00, 1'b0, 1'b0}; // 0/5

      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q",    quotient, 8'h00);
      chk("rst_r",    remainder, 8'h00);
      chk("rst_dz",   div_by_zero, 1'b0);
      chk("rst_ov",   overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         start_op(tv[i]);
         wait_done($sformatf("vec%0d", i), 9, 8);
      end

      // start during CALC with different operands is ignored
      start_op(tv[0]);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignore", 5, 4);
      expect_quiet("ignore", 15);

      // start held high through done: second op accepted on the done cycle
      a = tv[1];
      b = tv[8];
      @(negedge clk);
      dividend = a.a;
      divisor  = a.b;
      start    = 1'b1;
      sb.push_back(a);
      @(posedge clk);
      #1;
      chk("b2b_busy_a", busy, 1'b1);
      dividend = b.a;
      divisor  = b.b;
      sb.push_back(b);
      begin
         int lat;
         lat = 0;
         for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
               lat = k;
               break;
            end
         end
         chk("b2b_a_latency", lat, 9);
         if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            chk("b2b_a_q", quotient,  e.q);
            chk("b2b_a_r", remainder, e.r);
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_done_pulse", done, 1'b0);
      chk("b2b_busy_b", busy, 1'b1);
      chk("b2b_hold_q", quotient, 8'hF2);
      wait_done("b2b_b", 9, 8);

      // asynchronous reset in the middle of CALC discards the operation
      start_op(tv[0]);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_q",    quotient, 8'h00);
      chk("midrst_r",    remainder, 8'h00);
      chk("midrst_dz",   div_by_zero, 1'b0);
      chk("midrst_ov",   overflow, 1'b0);
      if (sb.size() > 0) void'(sb.pop_front());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("midrst", 15);
      start_op(tv[10]);
      wait_done("after_rst", 9, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
